// File: rtl/lcd_pkg.sv
// Shared constants, timing defaults and state types for the character-LCD
// command sequencer.
package lcd_pkg;

  localparam int N_CHARS_DEF   = 16;
  localparam int T_POWERON_DEF = 720000;
  localparam int T_CMD_DEF     = 1776;
  localparam int T_CLEAR_DEF   = 72960;
  localparam int N_INIT        = 6;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] DDRAM_L1      = 8'h80;

  typedef enum logic [2:0] {
    PWR_WAIT,
    LOAD,
    ISSUE,
    WAIT_DONE,
    RELEASE,
    IDLE
  } state_t;

  typedef enum logic {
    INIT,
    LINE
  } mode_t;

endpackage

// File: rtl/lcd_cmd_sequencer_init_rom.sv
// Power-on init table: maps an init step to its command byte and the
// execution wait the enable stage must honour after it.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int T_CMD   = T_CMD_DEF,
  parameter int T_CLEAR = T_CLEAR_DEF
) (
  input  logic [4:0]  step,
  output logic [7:0]  cmd_byte,
  output logic [22:0] cmd_wait
);

  // Function set is sent three times so the controller locks into 8-bit mode
  always_comb begin
    cmd_byte = FUNC_SET_8B2L;
    case (step)
      5'd0, 5'd1, 5'd2: cmd_byte = FUNC_SET_8B2L;
      5'd3:             cmd_byte = DISP_ON;
      5'd4:             cmd_byte = CLEAR;
      5'd5:             cmd_byte = ENTRY_INC;
      default:          cmd_byte = FUNC_SET_8B2L;
    endcase
    cmd_wait = (cmd_byte == CLEAR) ? 23'(T_CLEAR) : 23'(T_CMD);
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// HD44780 command sequencer: power-on wait, init table, then one 16-char
// line per host request, handing each byte to the enable-pulse stage.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int T_POWERON = T_POWERON_DEF,
  parameter int T_CMD     = T_CMD_DEF,
  parameter int T_CLEAR   = T_CLEAR_DEF,
  parameter int N_CHARS   = N_CHARS_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [8*N_CHARS-1:0] line_text,
  input  logic                 upd_req,
  output logic                 upd_ack,
  output logic                 init_done,
  output logic                 busy,
  output logic                 LCD_RS,
  output logic [7:0]           LCD_DATA,
  output logic [22:0]          wait_time_enable,
  output logic                 flag_rst_enable,
  input  logic                 flag_xs_enable
);

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic [19:0]          counter_q, counter_d;
  logic [4:0]           step_q, step_d;
  logic [8*N_CHARS-1:0] line_buf_q, line_buf_d;

  logic                 rs_d, flag_d, init_done_d, upd_ack_d;
  logic [7:0]           data_d;
  logic [22:0]          wait_d;

  logic [7:0]           rom_byte;
  logic [22:0]          rom_wait;
  logic [7:0]           line_byte;
  logic                 last_step;

  lcd_init_rom #(
    .T_CMD   (T_CMD),
    .T_CLEAR (T_CLEAR)
  ) u_init_rom (
    .step     (step_q),
    .cmd_byte (rom_byte),
    .cmd_wait (rom_wait)
  );

  // Step 1 addresses char 0, which sits in the most significant byte
  always_comb begin
    line_byte = 8'h00;
    for (int i = 0; i < N_CHARS; i++) begin
      if (step_q == 5'(i + 1)) line_byte = line_buf_q[8*(N_CHARS-1-i) +: 8];
    end
  end

  assign last_step = (mode_q == INIT) ? (step_q == 5'(N_INIT - 1))
                                      : (step_q == 5'(N_CHARS));
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    counter_d   = counter_q;
    step_d      = step_q;
    line_buf_d  = line_buf_q;
    rs_d        = LCD_RS;
    data_d      = LCD_DATA;
    wait_d      = wait_time_enable;
    flag_d      = flag_rst_enable;
    init_done_d = init_done;
    upd_ack_d   = 1'b0;

    case (state_q)
      PWR_WAIT: begin
        flag_d = 1'b1;
        if (counter_q == 20'(T_POWERON - 1)) begin
          counter_d = '0;
          step_d    = '0;
          mode_d    = INIT;
          state_d   = LOAD;
        end else begin
          counter_d = counter_q + 20'd1;
        end
      end
      LOAD: begin
        if (mode_q == INIT) begin
          rs_d   = 1'b0;
          data_d = rom_byte;
          wait_d = rom_wait;
        end else if (step_q == 5'd0) begin
          rs_d   = 1'b0;
          data_d = DDRAM_L1;
          wait_d = 23'(T_CMD);
        end else begin
          rs_d   = 1'b1;
          data_d = line_byte;
          wait_d = 23'(T_CMD);
        end
        state_d = ISSUE;
      end
      ISSUE: begin
        flag_d  = 1'b0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (flag_xs_enable) state_d = RELEASE;
      end
      // Re-arming the enable stage here guarantees a one-cycle gap per byte
      RELEASE: begin
        flag_d = 1'b1;
        if (last_step) begin
          if (mode_q == INIT) init_done_d = 1'b1;
          else                upd_ack_d   = 1'b1;
          state_d = IDLE;
        end else begin
          step_d  = step_q + 5'd1;
          state_d = LOAD;
        end
      end
      IDLE: begin
        flag_d = 1'b1;
        if (upd_req) begin
          line_buf_d = line_text;
          mode_d     = LINE;
          step_d     = '0;
          state_d    = LOAD;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q          <= PWR_WAIT;
      mode_q           <= INIT;
      counter_q        <= '0;
      step_q           <= '0;
      line_buf_q       <= '0;
      LCD_RS           <= 1'b0;
      LCD_DATA         <= 8'h00;
      wait_time_enable <= '0;
      flag_rst_enable  <= 1'b1;
      init_done        <= 1'b0;
      upd_ack          <= 1'b0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      counter_q        <= counter_d;
      step_q           <= step_d;
      line_buf_q       <= line_buf_d;
      LCD_RS           <= rs_d;
      LCD_DATA         <= data_d;
      wait_time_enable <= wait_d;
      flag_rst_enable  <= flag_d;
      init_done        <= init_done_d;
      upd_ack          <= upd_ack_d;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Scoreboard bench for lcd_cmd_sequencer: a model enable stage answers each
// byte, and a monitor checks every issued byte against expected traffic.
module tb_lcd_cmd_sequencer;

  localparam int TPW        = 200;
  localparam int NC         = 16;
  localparam int DONE_DELAY = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [8*NC-1:0] line_text;
  logic          upd_req;
  logic          upd_ack, init_done, busy, lcd_rs;
  logic [7:0]    lcd_data;
  logic [22:0]   wait_time;
  logic          flag_rst;
  logic          flag_xs;
  logic          spur;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            issued = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   cur_byte = '0;
  logic          prev_flag = 1'b1;
  logic          hold_chk = 1'b1;
  int            en_cnt = 0;

  always #5 clk = ~clk;

  lcd_cmd_sequencer #(.T_POWERON(TPW)) dut (
    .CLK              (clk),
    .RST              (rst),
    .line_text        (line_text),
    .upd_req          (upd_req),
    .upd_ack          (upd_ack),
    .init_done        (init_done),
    .busy             (busy),
    .LCD_RS           (lcd_rs),
    .LCD_DATA         (lcd_data),
    .wait_time_enable (wait_time),
    .flag_rst_enable  (flag_rst),
    .flag_xs_enable   (flag_xs)
  );

  // Enable stage model: done holds from DONE_DELAY cycles after release until re-armed
  always @(posedge clk) begin
    if (flag_rst) en_cnt <= 0;
    else if (en_cnt < 1000) en_cnt <= en_cnt + 1;
  end
  assign flag_xs = (!flag_rst && en_cnt >= DONE_DELAY) || spur;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mkByte(input logic rs, input logic [7:0] d);
    logic [22:0] w;
    w = (!rs && d == 8'h01) ? 23'd72960 : 23'd1776;
    return {rs, d, w};
  endfunction

  task automatic pushInit();
    logic [7:0] tbl [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    foreach (tbl[i]) exp_q.push_back(mkByte(1'b0, tbl[i]));
  endtask

  task automatic pushLine(input logic [8*NC-1:0] text);
    exp_q.push_back(mkByte(1'b0, 8'h80));
    for (int i = 0; i < NC; i++) exp_q.push_back(mkByte(1'b1, text[8*(NC-1-i) +: 8]));
  endtask

  function automatic logic [8*NC-1:0] randText();
    logic [8*NC-1:0] t;
    for (int i = 0; i < NC; i++) t[8*i +: 8] = 8'($urandom_range(32, 126));
    return t;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Monitor: a falling flag_rst_enable means a byte was handed to the enable stage
  always @(negedge clk) begin
    if (rst) begin
      prev_flag = 1'b1;
    end else begin
      if (prev_flag && !flag_rst) begin
        issued++;
        cur_byte = {lcd_rs, lcd_data, wait_time};
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL unexpected_byte: got %0h expected none at %0t", cur_byte, $time);
        end else begin
          checkOutput("issued_byte", cur_byte, exp_q.pop_front());
        end
      end else if (!prev_flag && flag_rst && hold_chk) begin
        checkOutput("held_through_release", {lcd_rs, lcd_data, wait_time}, cur_byte);
      end
      prev_flag = flag_rst;
    end
  end

  // Power-on hold is the wait itself plus the LOAD and ISSUE cycles
  task automatic measurePowerOn();
    int cnt = 0;
    while (flag_rst === 1'b1 && cnt < TPW + 100) begin
      spur = (cnt == 50);
      tick();
      cnt++;
    end
    spur = 1'b0;
    checkOutput("poweron_hold_cycles", 32'(cnt), 32'(TPW + 2));
  endtask

  task automatic waitInitDone(input int base);
    int cnt = 0;
    while (init_done !== 1'b1 && cnt < 3000) begin
      tick();
      cnt++;
    end
    checkOutput("init_done", 32'(init_done), 32'd1);
    checkOutput("init_byte_count", 32'(issued - base), 32'd6);
    checkOutput("idle_after_init", 32'(busy), 32'd0);
  endtask

  task automatic waitAck(input int base);
    int cnt = 0;
    while (upd_ack !== 1'b1 && cnt < 3000) begin
      tick();
      cnt++;
    end
    checkOutput("upd_ack", 32'(upd_ack), 32'd1);
    upd_req = 1'b0;
    checkOutput("line_byte_count", 32'(issued - base), 32'(NC + 1));
    tick();
    checkOutput("ack_one_cycle", 32'(upd_ack), 32'd0);
    checkOutput("idle_after_line", 32'(busy), 32'd0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic applyStimulus(input logic [8*NC-1:0] text, input logic scramble);
    int base;
    pushLine(text);
    line_text = text;
    upd_req   = 1'b1;
    tick();
    checkOutput("busy_after_req", 32'(busy), 32'd1);
    if (scramble) line_text = randText();
    base = issued;
    waitAck(base);
  endtask

  initial begin
    int base, cnt;
    logic [8*NC-1:0] t2;
    rst = 1'b1; upd_req = 1'b0; line_text = '0; spur = 1'b0;
    repeat (3) tick();
    checkOutput("rst_flag", 32'(flag_rst), 32'd1);
    checkOutput("rst_outputs", {lcd_rs, lcd_data, wait_time}, 32'd0);
    checkOutput("rst_status", {29'd0, init_done, upd_ack, busy}, 32'd1);

    pushInit();
    base = issued;
    rst = 1'b0;
    measurePowerOn();
    waitInitDone(base);

    base = issued;
    spur = 1'b1;
    repeat (3) tick();
    spur = 1'b0;
    repeat (10) tick();
    checkOutput("idle_spurious_bytes", 32'(issued - base), 32'd0);
    checkOutput("idle_spurious_busy", 32'(busy), 32'd0);

    applyStimulus("TEMP: 23.5 C    ", 1'b0);
    applyStimulus(randText(), 1'b1);
    applyStimulus(randText(), 1'b1);
    applyStimulus(randText(), 1'b0);

    // Abort a line write while char 7 is waiting on the enable stage
    t2 = randText();
    pushLine(t2);
    line_text = t2;
    upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
    base = issued;
    cnt = 0;
    while (!((issued - base) == 9 && flag_rst === 1'b0) && cnt < 3000) begin
      tick();
      cnt++;
    end
    checkOutput("reached_char7", 32'(issued - base), 32'd9);
    hold_chk = 1'b0;
    rst = 1'b1;
    tick();
    checkOutput("abort_flag", 32'(flag_rst), 32'd1);
    checkOutput("abort_init_done", 32'(init_done), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd1);

    exp_q.delete();
    pushInit();
    t2 = randText();
    pushLine(t2);
    line_text = t2;
    upd_req = 1'b1;
    base = issued;
    rst = 1'b0;
    measurePowerOn();
    hold_chk = 1'b1;
    waitInitDone(base);
    tick();
    checkOutput("line_starts_after_idle", 32'(busy), 32'd1);
    base = issued;
    waitAck(base);

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
